// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU: datapath width, op code values
// (the controller uses the same values) and small helper functions.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 5;
    localparam int SHAMT_W = 5;

    // Op codes driven by the ALU controller. Codes 10..31 behave as ALU_ADD.
    localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [OP_W-1:0] ALU_SLL  = 5'd2;
    localparam logic [OP_W-1:0] ALU_SLT  = 5'd3;
    localparam logic [OP_W-1:0] ALU_SLTU = 5'd4;
    localparam logic [OP_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [OP_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [OP_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [OP_W-1:0] ALU_OR   = 5'd8;
    localparam logic [OP_W-1:0] ALU_AND  = 5'd9;

    // Shifter direction / fill selection.
    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_mode_e;

    // Reverses the bit order of a word; lets one right-shifter serve left shifts.
    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    // True for the ops that need the subtract path of the shared adder.
    function automatic logic needs_subtract(input logic [OP_W-1:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

    // Maps an ALU op to the shifter mode; non-shift ops return SH_SLL (unused).
    function automatic shift_mode_e shift_mode_of(input logic [OP_W-1:0] op);
        shift_mode_e m;
        case (op)
            ALU_SRL: m = SH_SRL;
            ALU_SRA: m = SH_SRA;
            default: m = SH_SLL;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// 32-bit logarithmic barrel shifter. Left shifts reuse the right-shift
// network by reversing the word on the way in and out. Fill is zero except
// for arithmetic right shifts, which replicate data[31].
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_mode_e        mode,
    output logic [DATA_W-1:0]  result
);

    logic              is_left;
    logic              fill;
    logic [DATA_W-1:0] stage_in;
    logic [DATA_W-1:0] stage [0:SHAMT_W];

    // Select pre-reversal and fill bit from the shift mode.
    always_comb begin
        is_left  = (mode == SH_SLL);
        fill     = (mode == SH_SRA) ? data[DATA_W-1] : 1'b0;
        stage_in = is_left ? bit_reverse(data) : data;
    end

    assign stage[0] = stage_in;

    // Each level shifts right by 2^i when shamt[i] is set.
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_level
        localparam int SH = 1 << i;
        assign stage[i+1] = shamt[i] ? {{SH{fill}}, stage[i][DATA_W-1:SH]} : stage[i];
    end

    // Undo the input reversal for left shifts.
    always_comb begin
        result = is_left ? bit_reverse(stage[SHAMT_W]) : stage[SHAMT_W];
    end

endmodule

// File: rtl/alu_core.sv
// Combinational RV32I ALU. One adder serves ADD, SUB, SLT and SLTU; the
// compares are derived from the subtract result and operand signs. The
// result is forced to zero while RST_X is low, without any clocked state,
// so it follows the inputs again the moment reset is released.
module alu_core
    import alu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_X,
    input  logic [DATA_W-1:0] lhs,
    input  logic [DATA_W-1:0] rhs,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] res
);

    // The clock port exists only for interface uniformity with other units.
    logic unused_clk;
    assign unused_clk = CLK;

    logic                     sub_sel;
    logic [DATA_W-1:0]        rhs_eff;
    logic [DATA_W:0]          sum_ext;
    logic [DATA_W-1:0]        sum;
    logic                     carry_out;
    logic                     borrow;
    logic signed [DATA_W-1:0] lhs_s;
    logic signed [DATA_W-1:0] rhs_s;
    logic signed [DATA_W-1:0] diff_s;
    logic                     lt_signed;
    logic                     lt_unsigned;
    logic [DATA_W-1:0]        logic_res;
    logic [DATA_W-1:0]        shift_res;
    logic [DATA_W-1:0]        alu_res;
    shift_mode_e              sh_mode;

    // Shared adder/subtractor: subtraction is lhs + ~rhs + 1.
    always_comb begin
        sub_sel   = needs_subtract(op);
        rhs_eff   = sub_sel ? ~rhs : rhs;
        sum_ext   = {1'b0, lhs} + {1'b0, rhs_eff} + {{DATA_W{1'b0}}, sub_sel};
        sum       = sum_ext[DATA_W-1:0];
        carry_out = sum_ext[DATA_W];
    end

    // Compares: a borrow means lhs < rhs unsigned; for signed, differing
    // signs decide directly (avoids overflow), otherwise the difference sign.
    always_comb begin
        lhs_s       = $signed(lhs);
        rhs_s       = $signed(rhs);
        diff_s      = $signed(sum);
        borrow      = ~carry_out;
        lt_unsigned = borrow;
        if (lhs_s[DATA_W-1] != rhs_s[DATA_W-1]) begin
            lt_signed = lhs_s[DATA_W-1];
        end else begin
            lt_signed = diff_s[DATA_W-1];
        end
    end

    // Bitwise logic unit.
    always_comb begin
        case (op)
            ALU_XOR: logic_res = lhs ^ rhs;
            ALU_OR:  logic_res = lhs | rhs;
            default: logic_res = lhs & rhs;
        endcase
    end

    assign sh_mode = shift_mode_of(op);

    alu_shifter u_shifter (
        .data   (lhs),
        .shamt  (rhs[SHAMT_W-1:0]),
        .mode   (sh_mode),
        .result (shift_res)
    );

    // Result select; unassigned codes fall back to the adder output.
    always_comb begin
        case (op)
            ALU_SUB:                   alu_res = sum;
            ALU_SLT:                   alu_res = {{(DATA_W-1){1'b0}}, lt_signed};
            ALU_SLTU:                  alu_res = {{(DATA_W-1){1'b0}}, lt_unsigned};
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = shift_res;
            ALU_XOR, ALU_OR, ALU_AND:  alu_res = logic_res;
            default:                   alu_res = sum;
        endcase
    end

    // Asynchronous reset gating of the output.
    always_comb begin
        res = RST_X ? alu_res : '0;
    end

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed vectors with literal expectations, plus a
// per-cycle compare of the DUT against a behavioural model.
module tb_alu_core;

    logic        CLK;
    logic        RST_X;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  op;
    logic [31:0] res;

    int checks;
    int errors;
    logic compare_en;

    alu_core dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .lhs   (lhs),
        .rhs   (rhs),
        .op    (op),
        .res   (res)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural reference written from the instruction semantics.
    function automatic logic [31:0] model(input logic [31:0] l, input logic [31:0] r,
                                          input logic [4:0] o, input logic rstn);
        int unsigned sh;
        logic signed [31:0] ls;
        if (!rstn) return 32'd0;
        sh = r % 32;
        ls = l;
        case (o)
            5'd1: return l - r;
            5'd2: return l << sh;
            5'd3: return (ls < $signed(r)) ? 32'd1 : 32'd0;
            5'd4: return (l < r) ? 32'd1 : 32'd0;
            5'd5: return l ^ r;
            5'd6: return l >> sh;
            5'd7: begin
                ls = ls >>> sh;
                return ls;
            end
            5'd8: return l | r;
            5'd9: return l & r;
            default: return l + r;
        endcase
    endfunction

    // Per-cycle compare against the model while stimulus is stable.
    always @(posedge CLK) begin
        if (compare_en) begin
            checks = checks + 1;
            if (res !== model(lhs, rhs, op, RST_X)) begin
                errors = errors + 1;
                $display("FAIL model_cmp op=%0d lhs=%h rhs=%h rst_x=%b got=%h exp=%h",
                         op, lhs, rhs, RST_X, res, model(lhs, rhs, op, RST_X));
            end
        end
    end

    // Compares the DUT output with a literal, and the model with that literal.
    task automatic expect_res(input string name, input logic [31:0] exp);
        checks = checks + 1;
        if (res !== exp) begin
            errors = errors + 1;
            $display("FAIL %s dut got=%h exp=%h", name, res, exp);
        end
        checks = checks + 1;
        if (model(lhs, rhs, op, RST_X) !== exp) begin
            errors = errors + 1;
            $display("FAIL %s model got=%h exp=%h", name, model(lhs, rhs, op, RST_X), exp);
        end
    endtask

    // Drives one vector away from the rising edge and checks it.
    task automatic vec(input string name, input logic [4:0] o, input logic [31:0] l,
                       input logic [31:0] r, input logic [31:0] exp);
        @(negedge CLK);
        op  = o;
        lhs = l;
        rhs = r;
        #1;
        expect_res(name, exp);
    endtask

    logic [31:0] edge_vals [0:7];

    initial begin
        checks     = 0;
        errors     = 0;
        compare_en = 1'b0;
        RST_X      = 1'b0;
        lhs        = 32'd5;
        rhs        = 32'd7;
        op         = 5'd0;
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'h0000_0001;
        edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h8000_0000;
        edge_vals[4] = 32'h7FFF_FFFF;
        edge_vals[5] = 32'h0000_001F;
        edge_vals[6] = 32'h0000_0020;
        edge_vals[7] = 32'hF0F0_F0F0;

        // Reset gating and release without a clock edge.
        @(negedge CLK);
        #1;
        expect_res("reset_zero", 32'd0);
        #1;
        RST_X = 1'b1;
        #1;
        expect_res("reset_release", 32'd12);
        compare_en = 1'b1;

        vec("add_wrap",   5'd0, 32'hFFFF_FFFF, 32'd1,        32'd0);
        vec("sub_wrap",   5'd1, 32'd0,         32'd1,        32'hFFFF_FFFF);
        vec("sub_10_3",   5'd1, 32'd10,        32'd3,        32'd7);
        vec("slt_neg",    5'd3, 32'hFFFF_FFFF, 32'd1,        32'd1);
        vec("sltu_neg",   5'd4, 32'hFFFF_FFFF, 32'd1,        32'd0);
        vec("slt_eq",     5'd3, 32'd5,         32'd5,        32'd0);
        vec("sltu_0_1",   5'd4, 32'd0,         32'd1,        32'd1);
        vec("slt_ovf",    5'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
        vec("sltu_big",   5'd4, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1);
        vec("sll_31",     5'd2, 32'd1,         32'd31,       32'h8000_0000);
        vec("srl_31",     5'd6, 32'h8000_0000, 32'd31,       32'd1);
        vec("sra_4",      5'd7, 32'h8000_0000, 32'd4,        32'hF800_0000);
        vec("sra_pos",    5'd7, 32'h4000_0000, 32'd4,        32'h0400_0000);
        vec("sll_mask",   5'd2, 32'd1,         32'h21,       32'd2);
        vec("srl_mask",   5'd6, 32'h8000_0000, 32'hFFFF_FFE1, 32'h4000_0000);
        vec("sll_0",      5'd2, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF);
        vec("srl_0",      5'd6, 32'hDEAD_BEEF, 32'h20,       32'hDEAD_BEEF);
        vec("sra_0",      5'd7, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF);
        vec("xor",        5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        vec("or",         5'd8, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        vec("and",        5'd9, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        vec("undef_31",   5'd31, 32'd3,        32'd4,        32'd7);
        vec("undef_10",   5'd10, 32'd100,      32'd23,       32'd123);

        // Reset asserted mid-operation drops the output without a clock edge.
        @(negedge CLK);
        op  = 5'd5;
        lhs = 32'h1234_5678;
        rhs = 32'h0F0F_0F0F;
        #1;
        RST_X = 1'b0;
        #1;
        expect_res("reset_mid", 32'd0);
        #1;
        RST_X = 1'b1;
        #1;
        expect_res("reset_mid_rel", 32'h1D3B_5977);

        // Sweep of all ops, mixing random and boundary operands.
        for (int i = 0; i < 10000; i++) begin
            @(negedge CLK);
            op  = (i % 50 == 49) ? 5'($urandom_range(10, 31)) : 5'(i % 10);
            lhs = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 7)] : $urandom;
            rhs = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 7)] : $urandom;
        end

        @(negedge CLK);
        compare_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #500000;
        $display("FAIL timeout sim_time=%0t limit=500000", $time);
        $fatal(1, "timeout");
    end

endmodule
